// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with PC, instruction register,
//               valid/ready hand-off to decode and branch redirect/flush.
//               Optional halt-opcode stop enabled by macro FETCH_HALT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [7:0] HALT_OPCODE = 8'hFF,
    parameter logic [7:0] RESET_PC    = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_instr,
    input  logic       br_taken,
    input  logic [7:0] br_target,
    output logic [7:0] ir_out,
    output logic [7:0] pc_out,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic       halted
);

    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_pc_out;
    logic       r_ir_valid;
    logic       w_slot_free;

    assign w_slot_free = ~r_ir_valid | ir_ready;
    assign imem_addr   = r_pc;
    assign ir_out      = r_ir;
    assign pc_out      = r_pc_out;
    assign ir_valid    = r_ir_valid;

`ifdef FETCH_HALT_EN
    localparam logic [0:0] c_st_fetch = 1'b0;
    localparam logic [0:0] c_st_halt  = 1'b1;

    logic [0:0] r_state;
    logic       r_halted;
    logic       w_is_halt;

    assign w_is_halt = (imem_instr == HALT_OPCODE);
    assign halted    = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= 8'h00;
            r_pc_out   <= 8'h00;
            r_ir_valid <= 1'b0;
            r_state    <= c_st_fetch;
            r_halted   <= 1'b0;
        end else if (br_taken) begin
            // Redirect wins over everything, including a pending capture.
            r_pc       <= br_target;
            r_ir_valid <= 1'b0;
            r_state    <= c_st_fetch;
            r_halted   <= 1'b0;
        end else if (r_state == c_st_fetch) begin
            if (w_slot_free) begin
                r_ir       <= imem_instr;
                r_pc_out   <= r_pc;
                r_ir_valid <= 1'b1;
                if (w_is_halt) begin
                    // PC parks on the halt address so imem_addr stays there.
                    r_state  <= c_st_halt;
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= r_pc + 8'd1;
                end
            end
        end else begin
            if (r_ir_valid && ir_ready) begin
                r_ir_valid <= 1'b0;
            end
        end
    end
`else
    assign halted = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= 8'h00;
            r_pc_out   <= 8'h00;
            r_ir_valid <= 1'b0;
        end else if (br_taken) begin
            r_pc       <= br_target;
            r_ir_valid <= 1'b0;
        end else if (w_slot_free) begin
            r_ir       <= imem_instr;
            r_pc_out   <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic [7:0] imem_addr;
    logic [7:0] imem_instr;
    logic       br_taken;
    logic [7:0] br_target;
    logic [7:0] ir_out;
    logic [7:0] pc_out;
    logic       ir_valid;
    logic       ir_ready;
    logic       halted;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .ir_out     (ir_out),
        .pc_out     (pc_out),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .halted     (halted)
    );

    // Instruction memory: mem[i] = i + 8'h10, except mem[5] holds the halt opcode.
    assign imem_instr = (imem_addr == 8'h05) ? 8'hFF : imem_addr + 8'h10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag, input logic [7:0] ir, input logic [7:0] pc,
                            input logic v);
        check_eq({tag, ".ir"}, ir_out, ir);
        check_eq({tag, ".pc"}, pc_out, pc);
        check_eq({tag, ".valid"}, {7'd0, ir_valid}, {7'd0, v});
    endtask

    initial begin
        rst       = 1'b1;
        ir_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 8'h00;
        tick();
        tick();
        check_ir("reset", 8'h00, 8'h00, 1'b0);
        check_eq("reset.addr", imem_addr, 8'h00);
        check_eq("reset.halted", {7'd0, halted}, 8'h00);

        // Streaming
        rst      = 1'b0;
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_ir("stream", 8'h10 + 8'(i), 8'(i), 1'b1);
        end
        check_eq("stream.addr", imem_addr, 8'h04);

        // Backpressure
        ir_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_ir("stall", 8'h13, 8'h03, 1'b1);
            check_eq("stall.addr", imem_addr, 8'h04);
        end
        ir_ready = 1'b1;
        tick();
        check_ir("unstall", 8'h14, 8'h04, 1'b1);

        // Branch under stall
        ir_ready  = 1'b0;
        br_taken  = 1'b1;
        br_target = 8'h40;
        tick();
        br_taken = 1'b0;
        check_eq("br.valid", {7'd0, ir_valid}, 8'h00);
        check_eq("br.addr", imem_addr, 8'h40);
        tick();
        check_ir("br.capture", 8'h50, 8'h40, 1'b1);

        // Wrap-around
        ir_ready  = 1'b1;
        br_taken  = 1'b1;
        br_target = 8'hFE;
        tick();
        br_taken = 1'b0;
        check_eq("wrap.flush", {7'd0, ir_valid}, 8'h00);
        tick();
        check_ir("wrap.fe", 8'h0E, 8'hFE, 1'b1);
        tick();
        check_ir("wrap.ff", 8'h0F, 8'hFF, 1'b1);
        tick();
        check_ir("wrap.00", 8'h10, 8'h00, 1'b1);
        tick();
        check_ir("wrap.01", 8'h11, 8'h01, 1'b1);

        // Halt opcode at address 5
        br_taken  = 1'b1;
        br_target = 8'h04;
        tick();
        br_taken = 1'b0;
        tick();
        check_ir("halt.pre", 8'h14, 8'h04, 1'b1);
        tick();
        check_ir("halt.cap", 8'hFF, 8'h05, 1'b1);
        ir_ready = 1'b0;
`ifdef FETCH_HALT_EN
        check_eq("halt.halted", {7'd0, halted}, 8'h01);
        check_eq("halt.addr", imem_addr, 8'h05);
        tick();
        check_ir("halt.hold", 8'hFF, 8'h05, 1'b1);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check_eq("halt.drain", {7'd0, ir_valid}, 8'h00);
        check_eq("halt.addr2", imem_addr, 8'h05);
        tick();
        check_eq("halt.still", {7'd0, ir_valid}, 8'h00);
        check_eq("halt.halted2", {7'd0, halted}, 8'h01);
`else
        check_eq("nohalt.halted", {7'd0, halted}, 8'h00);
        check_eq("nohalt.addr", imem_addr, 8'h06);
        tick();
        check_ir("nohalt.hold", 8'hFF, 8'h05, 1'b1);
        ir_ready = 1'b1;
        tick();
        check_ir("nohalt.next", 8'h16, 8'h06, 1'b1);
`endif
        br_taken  = 1'b1;
        br_target = 8'h00;
        tick();
        br_taken = 1'b0;
        ir_ready = 1'b1;
        check_eq("resume.halted", {7'd0, halted}, 8'h00);
        check_eq("resume.addr", imem_addr, 8'h00);
        tick();
        check_ir("resume.0", 8'h10, 8'h00, 1'b1);
        tick();
        check_ir("resume.1", 8'h11, 8'h01, 1'b1);

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        check_ir("areset", 8'h00, 8'h00, 1'b0);
        check_eq("areset.addr", imem_addr, 8'h00);
        check_eq("areset.halted", {7'd0, halted}, 8'h00);
        #2;
        rst = 1'b0;
        tick();
        check_ir("areset.first", 8'h10, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
